// File: rtl/gray_step_checker.sv
// Gray-code step checker: decodes an upstream Gray count, tracks whether it advances
// by exactly +1 per sample, locks after LOCK_CNT good steps and counts errors and wraps.
module gray_step_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count,
  output logic [1:0]       fsm_state
);

  // Handshake: in_valid has no ready; every in_valid=1 cycle is consumed, and the
  // result appears one cycle later as a single-cycle bin_valid pulse.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] bin;
  logic [3:0]       good_run, good_run_nxt;
  logic [7:0]       err_count_nxt, wrap_count_nxt;
  logic             step_err_nxt;
  logic             is_step, is_hold;
  logic             acc;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    acc = 1'b0;
    bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray_in[i];
      bin[i] = acc;
    end
  end

  assign is_step   = (bin == WIDTH'(prev + 1'b1));
  assign is_hold   = (bin == prev);
  assign locked    = (state == LOCKED);
  assign fsm_state = state;

  always_comb begin
    state_nxt      = state;
    good_run_nxt   = good_run;
    err_count_nxt  = err_count;
    wrap_count_nxt = wrap_count;
    step_err_nxt   = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          state_nxt    = ACQ;
          good_run_nxt = '0;
        end
        ACQ: begin
          if (is_step) begin
            good_run_nxt = 4'(good_run + 4'd1);
            if (4'(good_run + 4'd1) == LOCK_TGT) state_nxt = LOCKED;
          end else if (!is_hold) begin
            good_run_nxt = '0;
          end
        end
        LOCKED: begin
          if (is_step) begin
            if (prev == MAX_VAL && bin == '0) wrap_count_nxt = 8'(wrap_count + 8'd1);
          end else if (!is_hold) begin
            step_err_nxt = 1'b1;
            if (err_count != 8'hFF) err_count_nxt = 8'(err_count + 8'd1);
            good_run_nxt = '0;
            state_nxt    = ACQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      good_run   <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_nxt;
      good_run   <= good_run_nxt;
      err_count  <= err_count_nxt;
      wrap_count <= wrap_count_nxt;
      step_err   <= step_err_nxt;
      bin_valid  <= in_valid;
      if (in_valid) begin
        bin_out <= bin;
        prev    <= bin;
      end
    end
  end

endmodule

// File: tb/tb_gray_step_checker.sv
// Bench for gray_step_checker: fixed vector table, hand-written corner sequences and
// randomized traffic, all compared against a behavioural model of the checking rules.
module tb_gray_step_checker;

  localparam int W  = 4;
  localparam int LC = 2;
  localparam int N  = 1 << W;
  localparam int EW = W + 19;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] gray_in;
  logic [W-1:0] bin_out;
  logic         bin_valid, locked, step_err;
  logic [7:0]   err_count, wrap_count;
  logic [1:0]   fsm_state;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  gray_step_checker #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked), .step_err(step_err),
    .err_count(err_count), .wrap_count(wrap_count), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  int m_mode, m_prev, m_run, m_bin, m_errc, m_wrap;
  bit m_bv, m_se;

  // Reference decode: search the code whose Gray image is g.
  function automatic int gray_to_bin(input int g);
    for (int b = 0; b < N; b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  function automatic logic [W-1:0] to_gray(input int b);
    int m;
    m = b % N;
    return W'(m ^ (m >> 1));
  endfunction

  function automatic logic [EW-1:0] actual_word();
    return {bin_out, bin_valid, locked, step_err, err_count, wrap_count};
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [W-1:0] g);
    int b;
    if (r) begin
      m_mode = M_IDLE; m_prev = 0; m_run = 0; m_bin = 0;
      m_errc = 0; m_wrap = 0; m_bv = 0; m_se = 0;
    end else begin
      m_bv = v;
      m_se = 0;
      if (v) begin
        b = gray_to_bin(int'(g));
        m_bin = b;
        if (m_mode == M_IDLE) begin
          m_mode = M_ACQ;
          m_run  = 0;
        end else if (b == (m_prev + 1) % N) begin
          if (m_mode == M_ACQ) begin
            m_run++;
            if (m_run == LC) m_mode = M_LOCKED;
          end else if (m_prev == N - 1) begin
            m_wrap = (m_wrap + 1) % 256;
          end
        end else if (b != m_prev) begin
          if (m_mode == M_LOCKED) begin
            m_se   = 1;
            m_errc = (m_errc < 255) ? m_errc + 1 : 255;
            m_mode = M_ACQ;
          end
          m_run = 0;
        end
        m_prev = b;
      end
    end
    exp_q.push_back({W'(m_bin), m_bv, (m_mode == M_LOCKED), m_se, 8'(m_errc), 8'(m_wrap)});
  endtask

  // ---------------- driver
  task automatic apply(input bit r, input bit v, input logic [W-1:0] g, input string name);
    logic [EW-1:0] e;
    rst = r; in_valid = v; gray_in = g;
    @(posedge clk);
    #1;
    model_step(r, v, g);
    e = exp_q.pop_front();
    cmp(name, 32'(actual_word()), 32'(e));
  endtask

  typedef struct {
    bit r; bit v; logic [W-1:0] g;
    logic [W-1:0] bin; bit bv; bit lk; bit se; logic [7:0] ec; logic [7:0] wc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int p;
    tbl[0]  = '{0, 1, 4'b0000, 4'd0,  1, 0, 0, 8'd0, 8'd0};
    tbl[1]  = '{0, 1, 4'b0001, 4'd1,  1, 0, 0, 8'd0, 8'd0};
    tbl[2]  = '{0, 1, 4'b0011, 4'd2,  1, 1, 0, 8'd0, 8'd0};
    tbl[3]  = '{0, 1, 4'b0010, 4'd3,  1, 1, 0, 8'd0, 8'd0};
    tbl[4]  = '{0, 0, 4'b1111, 4'd3,  0, 1, 0, 8'd0, 8'd0};
    tbl[5]  = '{0, 1, 4'b0110, 4'd4,  1, 1, 0, 8'd0, 8'd0};
    tbl[6]  = '{0, 1, 4'b0110, 4'd4,  1, 1, 0, 8'd0, 8'd0};
    tbl[7]  = '{0, 1, 4'b0100, 4'd7,  1, 0, 1, 8'd1, 8'd0};
    tbl[8]  = '{0, 1, 4'b1100, 4'd8,  1, 0, 0, 8'd1, 8'd0};
    tbl[9]  = '{0, 1, 4'b1101, 4'd9,  1, 1, 0, 8'd1, 8'd0};
    tbl[10] = '{0, 1, 4'b1111, 4'd10, 1, 1, 0, 8'd1, 8'd0};

    rst = 1'b1; in_valid = 1'b0; gray_in = '0;
    apply(1, 0, '0, "reset_model");
    cmp("reset_outputs", 32'(actual_word()), 32'd0);
    cmp("reset_state", 32'(fsm_state), 32'(ST_IDLE));

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].g, $sformatf("tbl%0d_model", i));
      cmp($sformatf("tbl%0d", i), 32'(actual_word()),
          32'({tbl[i].bin, tbl[i].bv, tbl[i].lk, tbl[i].se, tbl[i].ec, tbl[i].wc}));
    end

    // locked at 10: run to 15, wrap to 0
    for (int b = 11; b < 16; b++) apply(0, 1, to_gray(b), "run_to_max");
    apply(0, 1, 4'b0000, "wrap");
    cmp("wrap_count", 32'(wrap_count), 32'd1);
    cmp("wrap_no_err", 32'({step_err, locked}), 32'b01);

    // locked at 1, jump to 3, then relock on 4,5
    apply(0, 1, 4'b0001, "at_one");
    apply(0, 1, 4'b0010, "bad_jump");
    cmp("bad_pulse", 32'({step_err, locked, err_count}), 32'({1'b1, 1'b0, 8'd2}));
    apply(0, 1, 4'b0110, "acq_step1");
    cmp("step_err_one_cycle", 32'(step_err), 32'd0);
    apply(0, 1, 4'b0111, "acq_step2");
    cmp("relock", 32'(locked), 32'd1);
    apply(0, 1, 4'b0101, "locked_step");
    cmp("stay_locked", 32'({locked, bin_out}), 32'({1'b1, 4'd6}));

    for (int i = 0; i < 5; i++) begin
      apply(0, 0, W'($urandom_range(0, N - 1)), "idle_gap");
      cmp("idle_no_valid", 32'({bin_valid, step_err, locked}), 32'b001);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 4'b0101, "hold");
      cmp("hold_locked", 32'({bin_valid, locked, bin_out}), 32'({1'b1, 1'b1, 4'd6}));
    end

    // drive err_count into saturation: bad, then two steps to relock
    for (int k = 0; k < 260; k++) begin
      p = m_prev;
      apply(0, 1, to_gray(p + 5), "sat_bad");
      apply(0, 1, to_gray(p + 6), "sat_relock1");
      apply(0, 1, to_gray(p + 7), "sat_relock2");
    end
    cmp("err_saturated", 32'({err_count, locked}), 32'({8'd255, 1'b1}));
    p = m_prev;
    apply(0, 1, to_gray(p + 9), "sat_extra_bad");
    cmp("sat_pulse", 32'({step_err, err_count}), 32'({1'b1, 8'd255}));
    apply(0, 1, to_gray(p + 10), "sat_relock1");
    apply(0, 1, to_gray(p + 11), "sat_relock2");
    cmp("locked_before_rst", 32'(locked), 32'd1);

    apply(1, 0, '0, "rst_locked");
    cmp("rst_locked_outputs", 32'(actual_word()), 32'd0);
    cmp("rst_locked_state", 32'(fsm_state), 32'(ST_IDLE));

    apply(0, 1, to_gray(3), "pre_rst_sample");
    apply(1, 1, to_gray(5), "rst_with_valid");
    cmp("rst_valid_bv", 32'({bin_valid, bin_out}), 32'd0);
    cmp("rst_valid_state", 32'(fsm_state), 32'(ST_IDLE));
    apply(0, 1, to_gray(9), "first_after_rst");
    cmp("first_after_rst", 32'({fsm_state, locked, bin_out}), 32'({ST_ACQ, 1'b0, 4'd9}));
    apply(0, 1, to_gray(12), "acq_bad");
    cmp("acq_bad_silent", 32'({step_err, err_count}), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      bit r, v;
      logic [W-1:0] g;
      sel = int'($urandom_range(0, 99));
      r   = ($urandom_range(0, 127) == 0);
      v   = ($urandom_range(0, 9) < 8);
      if (sel < 65)      g = to_gray(m_prev + 1);
      else if (sel < 80) g = to_gray(m_prev);
      else               g = W'($urandom_range(0, N - 1));
      apply(r, v, g, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
